accum_sched: RTL and testbench



---
 rtl/accum_sched_pkg.sv | 18 +
 rtl/accum_sched_if.sv | 26 ++
 rtl/accum_sched_rr_arbiter.sv | 43 ++++
 rtl/accum_sched.sv | 114 +++++++++++
 tb/tb_accum_sched.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/accum_sched_pkg.sv
// Shared types and constants for the accumulator scheduler.
package accum_sched_pkg;

  localparam int ACC_W = 32;

  typedef enum logic [1:0] {
    ADD   = 2'd0,
    SUB   = 2'd1,
    READ  = 2'd2,
    CLEAR = 2'd3
  } acc_op_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

endpackage

// File: rtl/accum_sched_if.sv
// Request/response bundle between the requester fabric and the scheduler.
interface accum_sched_if
  import accum_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = ACC_W
) ();

  logic    [N_REQ-1:0]        req_valid;
  logic    [N_REQ-1:0]        req_ready;
  acc_op_t [N_REQ-1:0]        req_op;
  logic    [N_REQ-1:0][W-1:0] req_data;
  logic    [N_REQ-1:0]        rsp_valid;
  logic    [W-1:0]            rsp_data;

  modport master (
    output req_valid, req_op, req_data,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_data,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/accum_sched_rr_arbiter.sv
// Round-robin arbiter: searches from the slot after the last grant and
// advances its pointer only when a grant is issued.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] ptr_q;

  // Pointer starts at the last slot so requester 0 wins first after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IDX_W'(N_REQ - 1);
    end else if (grant_valid) begin
      ptr_q <= grant_idx;
    end
  end

  always_comb begin
    int idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_q) + 1 + i) % N_REQ;
      if (enable && !grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/accum_sched.sv
// Shares one accumulator between N_REQ requesters; clears the (reset-less)
// accumulator during reset/INIT and returns one registered response per grant.
module accum_sched
  import accum_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = ACC_W
) (
  input  logic          clk,
  input  logic          rst,
  accum_sched_if.slave  bus,
  output logic [W-1:0]  accum_in,
  output logic          accum_bypass,
  input  logic [W-1:0]  accum_out
);

  localparam int IDX_W = $clog2(N_REQ);

  sched_state_t     state_q, state_d;
  logic             arb_en;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;
  acc_op_t          grant_op;
  logic [W-1:0]     grant_data;

  logic             rsp_pend_q;
  logic [IDX_W-1:0] rsp_id_q;
  acc_op_t          rsp_kind_q;
  logic [W-1:0]     clear_val_q;
  logic             rsp_live;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.req_valid),
    .enable      (arb_en),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_any)
  );

  assign arb_en        = (state_q == RUN) && !rst;
  assign bus.req_ready = grant;
  assign grant_op      = bus.req_op[grant_idx];
  assign grant_data    = bus.req_data[grant_idx];
  assign accum_bypass  = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Clearing adds the negated total, so the accumulator lands on zero.
  always_comb begin
    state_d  = state_q;
    accum_in = '0;
    case (state_q)
      INIT: begin
        state_d  = RUN;
        accum_in = -accum_out;
      end
      RUN: begin
        if (grant_any) begin
          case (grant_op)
            ADD:   accum_in = grant_data;
            SUB:   accum_in = -grant_data;
            READ:  accum_in = '0;
            CLEAR: accum_in = -accum_out;
          endcase
        end
      end
      default: state_d = INIT;
    endcase
    if (rst) begin
      accum_in = -accum_out;
    end
  end

  // The pre-clear total must be captured at grant; afterwards it is gone.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend_q  <= 1'b0;
      rsp_id_q    <= '0;
      rsp_kind_q  <= READ;
      clear_val_q <= '0;
    end else begin
      rsp_pend_q <= grant_any;
      if (grant_any) begin
        rsp_id_q   <= grant_idx;
        rsp_kind_q <= grant_op;
        if (grant_op == CLEAR) begin
          clear_val_q <= accum_out;
        end
      end
    end
  end

  // A pending response is dropped outright if reset lands in its cycle.
  assign rsp_live = rsp_pend_q && !rst;

  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    if (rsp_live) begin
      bus.rsp_valid[rsp_id_q] = 1'b1;
      bus.rsp_data = (rsp_kind_q == CLEAR) ? clear_val_q : accum_out;
    end
  end

endmodule

// File: tb/tb_accum_sched.sv
// Directed bench for accum_sched with a behavioural reset-less accumulator.
module tb_accum_sched;
  import accum_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] accum_in;
  logic        accum_bypass;
  logic [31:0] total = 32'h0000_1234;

  int tests = 0;
  int fails = 0;

  accum_sched_if #(.N_REQ(4), .W(32)) bus ();

  accum_sched #(.N_REQ(4), .W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .accum_in     (accum_in),
    .accum_bypass (accum_bypass),
    .accum_out    (total)
  );

  always #5 clk = ~clk;

  // Protected accumulator: registered running total, no reset.
  always @(posedge clk) begin
    total <= accum_bypass ? accum_in : total + accum_in;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int id, input acc_op_t op, input logic [31:0] data);
    bus.req_valid    = 4'b0001 << id;
    bus.req_op[id]   = op;
    bus.req_data[id] = data;
  endtask

  // Issue one op from a single requester; entered and left #1 after a posedge.
  task automatic doOp(input int id, input acc_op_t op, input logic [31:0] data,
                      input logic [31:0] expected, input string tag);
    applyStimulus(id, op, data);
    #1;
    checkOutput({tag, "_ready"}, 32'(bus.req_ready), 32'h1 << id);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h1 << id);
    checkOutput({tag, "_rsp_data"}, bus.rsp_data, expected);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    for (int i = 0; i < 4; i++) bus.req_op[i] = ADD;

    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput("rst_ready", 32'(bus.req_ready), 32'h0);
      checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      checkOutput("rst_rsp_data", bus.rsp_data, 32'h0);
    end
    checkOutput("rst_total_cleared", total, 32'h0);
    checkOutput("rst_bypass", 32'(accum_bypass), 32'h0);

    rst = 1'b0;
    applyStimulus(0, READ, 32'h0);
    #1;
    checkOutput("init_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk);
    #1;
    doOp(0, READ, 32'h0, 32'h0, "read_after_reset");

    doOp(1, ADD, 32'd5, 32'd5, "add5");
    doOp(1, ADD, 32'd7, 32'd12, "add7");
    doOp(3, CLEAR, 32'h0, 32'd12, "clear12");
    doOp(2, ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "add_max");
    doOp(2, ADD, 32'd2, 32'd1, "add_wrap");
    doOp(1, SUB, 32'd3, 32'hFFFF_FFFE, "sub_wrap");
    doOp(3, CLEAR, 32'h0, 32'hFFFF_FFFE, "clear_neg");

    // Last grant was requester 3, so the rotation starts at 0.
    for (int i = 0; i < 4; i++) begin
      bus.req_op[i]   = ADD;
      bus.req_data[i] = 32'd1;
    end
    bus.req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      checkOutput($sformatf("fair_ready_%0d", k), 32'(bus.req_ready), 32'h1 << (k % 4));
      @(posedge clk);
      #1;
      if (k == 7) bus.req_valid = '0;
      checkOutput($sformatf("fair_rsp_valid_%0d", k), 32'(bus.rsp_valid), 32'h1 << (k % 4));
      checkOutput($sformatf("fair_rsp_data_%0d", k), bus.rsp_data, 32'(k + 1));
    end

    @(posedge clk);
    #1;
    checkOutput("idle_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("idle_accum_in", accum_in, 32'h0);
    checkOutput("idle_total", total, 32'd8);

    doOp(2, ADD, 32'd32, 32'd40, "add32");
    doOp(2, CLEAR, 32'h0, 32'd40, "clear40");
    doOp(2, READ, 32'h0, 32'h0, "read_after_clear");

    applyStimulus(0, ADD, 32'd9);
    #1;
    checkOutput("midrst_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_rsp_dropped", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("midrst_rsp_after", 32'(bus.rsp_valid), 32'h0);
    checkOutput("midrst_total", total, 32'h0);
    rst = 1'b0;
    applyStimulus(0, READ, 32'h0);
    #1;
    checkOutput("midrst_init_ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk);
    #1;
    doOp(0, READ, 32'h0, 32'h0, "read_after_midrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
